// File: rtl/gamepad_reader_if.sv
// Pins on the gamepad side plus the decoded outputs used by the sprite/motion logic.
interface gamepad_reader_if;
  logic       pad_data;
  logic       gameover;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       L, R, U, D;
  logic [1:0] cd;
  logic       frame_valid;

  modport slave (
    input  pad_data, gameover,
    output pad_latch, pad_clk, buttons, L, R, U, D, cd, frame_valid
  );

  modport master (
    output pad_data, gameover,
    input  pad_latch, pad_clk, buttons, L, R, U, D, cd, frame_valid
  );
endinterface

// File: rtl/gamepad_reader.sv
// Polls an NES-style latch/clock/data gamepad and produces raw buttons,
// cleaned direction strobes and a sticky current-direction code.
module gamepad_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 1666667
) (
  input  logic              clk,
  input  logic              reset,
  gamepad_reader_if.slave   bus
);
  localparam int PW  = $clog2(POLL_PERIOD);
  localparam int PHW = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_UPDATE} state_t;

  state_t           r_state, w_state_nx;
  logic [PW-1:0]    r_poll;
  logic [PHW-1:0]   r_ph, w_ph_nx;
  logic [2:0]       r_idx, w_idx_nx;
  logic             w_sample;
  logic             w_tick;
  logic [1:0]       r_sync;
  logic [7:0]       r_shift;

  logic             r_pad_latch, r_pad_clk;
  logic [7:0]       r_buttons;
  logic             r_l, r_r, r_u, r_d;
  logic [1:0]       r_cd, w_cd_nx;
  logic             r_frame_valid;

  logic             w_l, w_r, w_u, w_d;
  logic [3:0]       w_pressed, w_prev, w_new;

  assign w_tick = (r_poll == PW'(POLL_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_poll <= '0;
      r_sync <= 2'b11;
    end else begin
      r_poll <= w_tick ? '0 : r_poll + 1'b1;
      r_sync <= {r_sync[0], bus.pad_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
      r_idx   <= w_idx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = r_ph + 1'b1;
    w_idx_nx   = r_idx;
    w_sample   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ph_nx = '0;
        if (w_tick) w_state_nx = S_LATCH;
      end
      S_LATCH: begin
        if (r_ph == PHW'(2 * CLK_DIV - 1)) begin
          w_state_nx = S_LOW;
          w_ph_nx    = '0;
          w_idx_nx   = '0;
        end
      end
      S_LOW: begin
        if (r_ph == PHW'(CLK_DIV - 1)) begin
          w_sample   = 1'b1;
          w_ph_nx    = '0;
          w_state_nx = (r_idx == 3'd7) ? S_UPDATE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_ph == PHW'(CLK_DIV - 1)) begin
          w_state_nx = S_LOW;
          w_ph_nx    = '0;
          w_idx_nx   = r_idx + 1'b1;
        end
      end
      S_UPDATE: begin
        w_state_nx = S_IDLE;
        w_ph_nx    = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_ph_nx    = '0;
      end
    endcase
  end

  // Pad pins are registered off the next state so they toggle cleanly on an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b0;
      r_shift     <= '0;
    end else begin
      r_pad_latch <= (w_state_nx == S_LATCH);
      r_pad_clk   <= (w_state_nx == S_HIGH);
      if (w_sample) r_shift[r_idx] <= ~r_sync[1];
    end
  end

  assign w_l = r_shift[6] & ~r_shift[7] & ~bus.gameover;
  assign w_r = r_shift[7] & ~r_shift[6] & ~bus.gameover;
  assign w_u = r_shift[4] & ~r_shift[5] & ~bus.gameover;
  assign w_d = r_shift[5] & ~r_shift[4] & ~bus.gameover;

  // Indexed by cd encoding so bit n is the direction whose code is n.
  assign w_pressed = {w_l, w_d, w_r, w_u};
  assign w_prev    = {r_l, r_d, r_r, r_u};
  assign w_new     = w_pressed & ~w_prev;

  function automatic logic [1:0] pick(input logic [3:0] v);
    if (v[0])      pick = 2'b00;
    else if (v[1]) pick = 2'b01;
    else if (v[2]) pick = 2'b10;
    else           pick = 2'b11;
  endfunction

  always_comb begin
    w_cd_nx = r_cd;
    if (bus.gameover)                        w_cd_nx = r_cd;
    else if (|w_new)                         w_cd_nx = pick(w_new);
    else if (!w_pressed[r_cd] && |w_pressed) w_cd_nx = pick(w_pressed);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buttons     <= '0;
      r_l           <= 1'b0;
      r_r           <= 1'b0;
      r_u           <= 1'b0;
      r_d           <= 1'b0;
      r_cd          <= 2'b10;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= (r_state == S_UPDATE);
      if (r_state == S_UPDATE) begin
        r_buttons <= r_shift;
        r_l       <= w_l;
        r_r       <= w_r;
        r_u       <= w_u;
        r_d       <= w_d;
        r_cd      <= w_cd_nx;
      end
    end
  end

  assign bus.pad_latch   = r_pad_latch;
  assign bus.pad_clk     = r_pad_clk;
  assign bus.buttons     = r_buttons;
  assign bus.L           = r_l;
  assign bus.R           = r_r;
  assign bus.U           = r_u;
  assign bus.D           = r_d;
  assign bus.cd          = r_cd;
  assign bus.frame_valid = r_frame_valid;
endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: NES pad model, vector table and frame scoreboard.
module tb_gamepad_reader;
  localparam int CD = 4;
  localparam int PP = 200;

  logic clk = 1'b0;
  logic reset;
  gamepad_reader_if bus();

  gamepad_reader #(.CLK_DIV(CD), .POLL_PERIOD(PP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pad model: latch loads bit 0, each pad_clk rise advances one bit.
  logic [7:0] pad_btn = 8'h00;
  logic [3:0] pad_idx = 4'd0;
  always @(posedge bus.pad_latch or posedge bus.pad_clk)
    if (bus.pad_latch) pad_idx <= 4'd0;
    else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
  assign bus.pad_data = (pad_idx < 4'd8) ? ~pad_btn[pad_idx[2:0]] : 1'b0;

  typedef struct packed {
    logic [7:0] btn;
    logic [3:0] dirs;
    logic [1:0] cd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] btn;
    logic       go;
    logic [3:0] dirs;  // {L,R,U,D}
    logic [1:0] cd;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.frame_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected frame", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("buttons", {24'd0, bus.buttons}, {24'd0, e.btn});
        chk("dirs LRUD", {28'd0, bus.L, bus.R, bus.U, bus.D}, {28'd0, e.dirs});
        chk("cd", {30'd0, bus.cd}, {30'd0, e.cd});
      end
    end
  end

  task automatic wait_fv();
    int n;
    n = 0;
    while (bus.frame_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("frame timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("frame_valid one cycle", {31'd0, bus.frame_valid}, 32'd0);
  endtask

  task automatic measure_latch(output int t_lat);
    t_lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.pad_latch === 1'b1) begin
        t_lat = c;
        break;
      end
    end
  endtask

  initial begin
    int t_lat, lat_cnt, rises, hi_cnt, t_fv, n;
    logic prev_pc;

    vt[0]  = '{8'h10, 1'b0, 4'b0010, 2'b00};
    vt[1]  = '{8'hC0, 1'b0, 4'b0000, 2'b00};
    vt[2]  = '{8'h10, 1'b0, 4'b0010, 2'b00};
    vt[3]  = '{8'h90, 1'b0, 4'b0110, 2'b01};
    vt[4]  = '{8'h10, 1'b0, 4'b0010, 2'b00};
    vt[5]  = '{8'h20, 1'b1, 4'b0000, 2'b00};
    vt[6]  = '{8'h20, 1'b0, 4'b0001, 2'b10};
    vt[7]  = '{8'h30, 1'b0, 4'b0000, 2'b10};
    vt[8]  = '{8'h41, 1'b0, 4'b1000, 2'b11};
    vt[9]  = '{8'h00, 1'b0, 4'b0000, 2'b11};
    vt[10] = '{8'hF0, 1'b0, 4'b0000, 2'b11};
    vt[11] = '{8'hA0, 1'b0, 4'b0101, 2'b01};
    vt[12] = '{8'h0F, 1'b0, 4'b0000, 2'b01};

    reset = 1'b1;
    bus.gameover = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cd", {30'd0, bus.cd}, 32'd2);
    chk("reset outs", {19'd0, bus.buttons, bus.L, bus.R, bus.U, bus.D, bus.pad_latch},
        32'd0);
    reset = 1'b0;

    // First poll: exact pin timing, all buttons released.
    sb.push_back('{8'h00, 4'b0000, 2'b10});
    t_lat = -1; lat_cnt = 0; rises = 0; hi_cnt = 0; t_fv = -1; prev_pc = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (bus.pad_latch === 1'b1) begin
        if (t_lat < 0) t_lat = c;
        lat_cnt++;
      end
      if (bus.pad_clk === 1'b1) begin
        hi_cnt++;
        if (!prev_pc) rises++;
      end
      prev_pc = bus.pad_clk;
      if (bus.frame_valid === 1'b1) begin
        t_fv = c;
        break;
      end
    end
    chk("latch rise cycle", t_lat, 32'd200);
    chk("latch width", lat_cnt, 32'd8);
    chk("pad_clk pulses", rises, 32'd7);
    chk("pad_clk high cycles", hi_cnt, 32'd28);
    chk("frame_valid cycle", t_fv, 32'd269);
    @(negedge clk);

    foreach (vt[i]) begin
      pad_btn = vt[i].btn;
      bus.gameover = vt[i].go;
      sb.push_back('{vt[i].btn, vt[i].dirs, vt[i].cd});
      wait_fv();
    end

    // Reset during the HIGH phase of bit 3 (fourth pad_clk pulse).
    pad_btn = 8'hFF;
    bus.gameover = 1'b0;
    rises = 0; prev_pc = 1'b0; n = 0;
    while (rises < 4 && n < 600) begin
      @(negedge clk);
      n++;
      if (bus.pad_clk === 1'b1 && !prev_pc) rises++;
      prev_pc = bus.pad_clk;
    end
    chk("reached bit3 high", rises, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid reset pad_clk", {31'd0, bus.pad_clk}, 32'd0);
    chk("mid reset pad_latch", {31'd0, bus.pad_latch}, 32'd0);
    chk("mid reset cd", {30'd0, bus.cd}, 32'd2);
    chk("mid reset buttons", {24'd0, bus.buttons}, 32'd0);
    chk("mid reset fv", {31'd0, bus.frame_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.push_back('{8'hFF, 4'b0000, 2'b10});
    measure_latch(t_lat);
    chk("latch rise after mid reset", t_lat, 32'd200);
    wait_fv();
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
